register_en_clr: RTL and testbench
==================================

Name: register_en_clr

Overview:
- Parameterised-width, single-clock data register with load enable and synchronous clear.
- Generic pipeline and holding stage used wherever the datapath needs a word captured and held until a new load or a clear.
- Output is driven directly from the flops; there is no combinational path from input to output.

Parameters:
- BITWIDTH, 32, width of the data input and output in bits (legal range 1 or more).
- RESET_VAL, 0, value loaded on reset; BITWIDTH bits wide, zero-extended or truncated to BITWIDTH.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  synchronous active-high reset.
- iEn  input  1  load enable; when high, iData is captured on the next rising edge.
- iClr  input  1  synchronous clear; when high, the register is forced to 0 on the next rising edge.
- iData  input  BITWIDTH  data to load.
- oData  output  BITWIDTH  current register contents.

Behaviour:
- One clock iClk. Reset is synchronous and active-high.
- Single state element: a BITWIDTH-bit register q. oData = q at all times (registered output).
- Priority at each rising edge of iClk, highest first:
  - iRst=1: q <= RESET_VAL (default 0), regardless of iEn, iClr and iData.
  - iClr=1: q <= 0, regardless of iEn and iData.
  - iEn=1: q <= iData.
  - Otherwise: q holds its value.
- Latency:
  - iData appears on oData exactly 1 cycle after the edge that samples iEn=1.
  - Clear and reset also take effect on oData after that single edge.
- iClr held high for many cycles keeps q at 0 every cycle. Deasserting iClr with iEn=1 loads iData on the first edge where iClr=0.
- Reset mid-operation:
  - Any stored value is discarded at the first edge with iRst=1.
  - Reset held high holds RESET_VAL.
  - After reset deasserts, normal load/clear/hold resumes on the next edge.
- Before the first reset edge, oData is undefined. No behaviour is guaranteed until reset has been applied for at least one edge.
- Inputs are sampled only at rising edges. Changes between edges have no effect on oData.
- No asynchronous paths.
- Arithmetic: none. Data passes bit-for-bit; no sign handling, no width conversion beyond RESET_VAL fitting.

Test Plan:
- Reset: iRst=1 for 2 edges with iEn=1, iData=0xFFFFFFFF -> oData=0 (RESET_VAL) after the first edge and stays 0 while iRst=1.
- Load sequence: iRst=0, iEn=1, iClr=0. Drive iData = 10, 100, 1000, 10000 on successive cycles -> oData = 10, 100, 1000, 10000 on the edge after each value is presented, 1-cycle latency.
- Hold: after loading 10000, set iEn=0 and change iData to 0x12345678 -> oData stays 10000 for all following cycles.
- Clear: with oData=10000 and iEn=1, raise iClr and hold it for 40 cycles while iData=10000 -> oData=0 from the first edge and remains 0 for all 40 cycles.
- Clear release and priority:
  - Drop iClr with iEn=1, iData=55 -> oData=55 one edge later.
  - Assert iClr and iEn together -> oData=0.
- Reset mid-operation and parameterisation:
  - Assert iRst for one edge while oData=55 and iClr=0, iEn=1 -> oData=RESET_VAL.
  - Repeat with BITWIDTH=8, RESET_VAL=0xA5 -> oData=0xA5 after reset; loads of 0x3C and 0xFF pass through unchanged.

Source files
------------

// File: rtl/register_en_clr.sv
`default_nettype none
// ============================================================================
//  Module   : register_en_clr
//  Purpose  : Parameterised-width data register with load enable and
//             synchronous clear. The output comes straight from the flops,
//             so there is no combinational path from input to output.
//  Revision : 1.0  initial release
// ============================================================================
module register_en_clr #(
  parameter int unsigned          BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  output logic [BITWIDTH-1:0] oData
);

  // Value the register takes after a clear; distinct from RESET_VAL on purpose.
  localparam logic [BITWIDTH-1:0] c_CLR_VAL = '0;

  logic [BITWIDTH-1:0] data_d;
  logic [BITWIDTH-1:0] data_q;

  // Next-state selection: clear beats load, otherwise hold. Reset is handled
  // in the register itself so it overrides everything, including clear.
  always_comb begin
    data_d = data_q;
    if (iClr) begin
      data_d = c_CLR_VAL;
    end else if (iEn) begin
      data_d = iData;
    end
  end

  // Storage element with synchronous active-high reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign oData = data_q;

endmodule
`default_nettype wire

// File: tb/tb_register_en_clr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_en_clr
//  Purpose  : Directed testbench for register_en_clr, covering the default
//             32-bit / zero-reset build and an 8-bit build with RESET_VAL=0xA5.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_en_clr;

  logic        clk;
  int          checks;
  int          errors;

  // 32-bit instance, RESET_VAL = 0
  logic        rst_a, en_a, clr_a;
  logic [31:0] data_a, q_a;

  // 8-bit instance, RESET_VAL = 0xA5
  logic        rst_b, en_b, clr_b;
  logic [7:0]  data_b, q_b;

  register_en_clr #(
    .BITWIDTH  (32),
    .RESET_VAL (32'h0)
  ) u_dut_a (
    .iClk  (clk),
    .iRst  (rst_a),
    .iEn   (en_a),
    .iClr  (clr_a),
    .iData (data_a),
    .oData (q_a)
  );

  register_en_clr #(
    .BITWIDTH  (8),
    .RESET_VAL (8'hA5)
  ) u_dut_b (
    .iClk  (clk),
    .iRst  (rst_b),
    .iEn   (en_b),
    .iClr  (clr_b),
    .iData (data_b),
    .oData (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] load_vals [4];
    checks = 0;
    errors = 0;
    load_vals[0] = 32'd10;
    load_vals[1] = 32'd100;
    load_vals[2] = 32'd1000;
    load_vals[3] = 32'd10000;

    // Reset both instances for two edges with load enabled and all-ones data.
    rst_a = 1'b1; en_a = 1'b1; clr_a = 1'b0; data_a = 32'hFFFF_FFFF;
    rst_b = 1'b1; en_b = 1'b1; clr_b = 1'b0; data_b = 8'hFF;
    #2;
    step();
    chk_a("reset_edge1_a", q_a, 32'h0);
    chk_b("reset_edge1_b", q_b, 8'hA5);
    step();
    chk_a("reset_edge2_a", q_a, 32'h0);
    chk_b("reset_edge2_b", q_b, 8'hA5);

    // Instance B idles in hold while A is exercised.
    rst_b = 1'b0; en_b = 1'b0;

    // Load sequence, one-cycle latency.
    rst_a = 1'b0; en_a = 1'b1; clr_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_a = load_vals[i];
      step();
      chk_a($sformatf("load_%0d", i), q_a, load_vals[i]);
    end

    // Hold: enable low, data changes, output keeps 10000.
    en_a = 1'b0; data_a = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a($sformatf("hold_%0d", i), q_a, 32'd10000);
    end

    // Mid-cycle data wiggle with enable low must not matter either.
    @(negedge clk);
    data_a = 32'hDEAD_BEEF;
    step();
    chk_a("hold_midcycle", q_a, 32'd10000);

    // Clear held 40 cycles with enable high and data 10000.
    en_a = 1'b1; clr_a = 1'b1; data_a = 32'd10000;
    for (int i = 0; i < 40; i++) begin
      step();
      chk_a($sformatf("clear_%0d", i), q_a, 32'h0);
    end

    // Clear release loads on the first edge without clear.
    clr_a = 1'b0; data_a = 32'd55;
    step();
    chk_a("clr_release_load", q_a, 32'd55);

    // Clear beats enable.
    clr_a = 1'b1; en_a = 1'b1; data_a = 32'd77;
    step();
    chk_a("clr_over_en", q_a, 32'h0);

    // Reload 55 then reset mid-operation.
    clr_a = 1'b0; data_a = 32'd55;
    step();
    chk_a("reload_55", q_a, 32'd55);
    rst_a = 1'b1; en_a = 1'b1; clr_a = 1'b0; data_a = 32'd99;
    step();
    chk_a("mid_reset", q_a, 32'h0);

    // Reset beats clear too (A's reset value is 0, so check via B later).
    rst_a = 1'b0; data_a = 32'hCAFE_F00D;
    step();
    chk_a("post_reset_load", q_a, 32'hCAFE_F00D);
    chk_b("b_held_during_a", q_b, 8'hA5);

    // 8-bit build: loads pass through unchanged.
    en_b = 1'b1; data_b = 8'h3C;
    step();
    chk_b("b_load_3c", q_b, 8'h3C);
    data_b = 8'hFF;
    step();
    chk_b("b_load_ff", q_b, 8'hFF);

    // Clear gives 0, not RESET_VAL.
    clr_b = 1'b1;
    step();
    chk_b("b_clear", q_b, 8'h00);

    // Reset with clear also high gives RESET_VAL.
    rst_b = 1'b1;
    step();
    chk_b("b_rst_over_clr", q_b, 8'hA5);

    // Reset held keeps RESET_VAL, then normal load resumes.
    clr_b = 1'b0; data_b = 8'h5A;
    step();
    chk_b("b_rst_held", q_b, 8'hA5);
    rst_b = 1'b0;
    step();
    chk_b("b_post_reset_load", q_b, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
